// File: rtl/npem_control_status_handler.sv
// NPEM Control/Status owner: masks config writes, forwards commands to the enclosure, tracks completion.
// Command valid one cycle after an accepted write; holds under !encl_cmd_ready; writes while busy collapse into one pending slot.
module npem_control_status_handler #(
    parameter int REGISTER_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REGISTER_WIDTH-1:0] capabilities,
    input  logic                      ctrl_wr_en,
    input  logic [REGISTER_WIDTH-1:0] ctrl_wr_data,
    output logic [REGISTER_WIDTH-1:0] ctrl_rd_data,
    input  logic                      sts_wr_en,
    input  logic [REGISTER_WIDTH-1:0] sts_wr_data,
    output logic [REGISTER_WIDTH-1:0] sts_rd_data,
    output logic                      encl_cmd_valid,
    output logic [REGISTER_WIDTH-1:0] encl_cmd_data,
    input  logic                      encl_cmd_ready,
    input  logic                      encl_done,
    input  logic [7:0]                encl_status,
    output logic                      busy,
    output logic                      cmd_completed_irq,
    output logic                      cmd_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REGISTER_WIDTH-1:0] CTRL_MASK = REGISTER_WIDTH'(32'hFF00_0FFF);
    localparam logic [REGISTER_WIDTH-1:0] INIT_RESET_BIT = REGISTER_WIDTH'(32'h0000_0002);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] COMPLETE  = 2'd3;

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic [REGISTER_WIDTH-1:0] ctrl_q;
    logic [REGISTER_WIDTH-1:0] pend_q;
    logic                      pend_vld;
    logic [REGISTER_WIDTH-1:0] cmd_q;
    logic [CNT_W-1:0]          tmo_cnt;
    logic                      sts_cc;
    logic [7:0]                encl_sts_q;
    logic                      wr_acc;
    logic [REGISTER_WIDTH-1:0] wr_masked;
    logic                      tmo_hit;
    logic                      unused_sts_bits;

    assign wr_acc    = ctrl_wr_en & capabilities[0];
    assign wr_masked = ctrl_wr_data & capabilities & CTRL_MASK;
    // encl_done in the same cycle as the deadline is a real completion, not a timeout
    assign tmo_hit   = (state == WAIT_DONE) && !encl_done && (tmo_cnt == TMO_LAST);
    assign unused_sts_bits = ^sts_wr_data[REGISTER_WIDTH-1:1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (wr_acc) state_nxt = ISSUE;
            ISSUE:     if (encl_cmd_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (encl_done || tmo_hit) state_nxt = COMPLETE;
            COMPLETE:  state_nxt = (wr_acc || pend_vld) ? ISSUE : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ctrl_q            <= '0;
            pend_q            <= '0;
            pend_vld          <= 1'b0;
            cmd_q             <= '0;
            tmo_cnt           <= '0;
            sts_cc            <= 1'b0;
            encl_sts_q        <= '0;
            cmd_completed_irq <= 1'b0;
            cmd_timeout       <= 1'b0;
        end else begin
            state      <= state_nxt;
            encl_sts_q <= encl_status;

            if (wr_acc) ctrl_q <= wr_masked;

            // A write landing in COMPLETE is newer than anything pending, so it issues directly
            if (state == IDLE && wr_acc) begin
                cmd_q <= wr_masked;
            end else if (state == COMPLETE) begin
                if (wr_acc)        cmd_q <= wr_masked;
                else if (pend_vld) cmd_q <= pend_q;
            end

            if (state == COMPLETE) begin
                pend_vld <= 1'b0;
            end else if (wr_acc && state != IDLE) begin
                pend_vld <= 1'b1;
                pend_q   <= wr_masked;
            end

            if (state_nxt == ISSUE && state != ISSUE) begin
                tmo_cnt <= '0;
            end else if ((state == ISSUE || state == WAIT_DONE) && tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if (tmo_hit) cmd_timeout <= 1'b1;

            cmd_completed_irq <= (state == COMPLETE) && ctrl_q[0];

            if (state == COMPLETE)                 sts_cc <= 1'b1;
            else if (sts_wr_en && sts_wr_data[0])  sts_cc <= 1'b0;
        end
    end

    assign ctrl_rd_data   = ctrl_q & ~INIT_RESET_BIT;
    assign sts_rd_data    = {encl_sts_q, {(REGISTER_WIDTH-9){1'b0}}, sts_cc};
    assign encl_cmd_valid = (state == ISSUE);
    assign encl_cmd_data  = cmd_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_npem_control_status_handler.sv
// Self-checking bench for npem_control_status_handler: vector table, corner sequences, randomized run vs transaction model.
module tb_npem_control_status_handler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] capabilities;
    logic        ctrl_wr_en;
    logic [31:0] ctrl_wr_data;
    logic [31:0] ctrl_rd_data;
    logic        sts_wr_en;
    logic [31:0] sts_wr_data;
    logic [31:0] sts_rd_data;
    logic        encl_cmd_valid;
    logic [31:0] encl_cmd_data;
    logic        encl_cmd_ready;
    logic        encl_done;
    logic [7:0]  encl_status;
    logic        busy;
    logic        cmd_completed_irq;
    logic        cmd_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int irq_cnt  = 0;
    int fire_cnt = 0;
    logic [31:0] last_fire = '0;

    always #5 clk = ~clk;

    npem_control_status_handler #(.REGISTER_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .capabilities(capabilities),
        .ctrl_wr_en(ctrl_wr_en), .ctrl_wr_data(ctrl_wr_data), .ctrl_rd_data(ctrl_rd_data),
        .sts_wr_en(sts_wr_en), .sts_wr_data(sts_wr_data), .sts_rd_data(sts_rd_data),
        .encl_cmd_valid(encl_cmd_valid), .encl_cmd_data(encl_cmd_data), .encl_cmd_ready(encl_cmd_ready),
        .encl_done(encl_done), .encl_status(encl_status), .busy(busy),
        .cmd_completed_irq(cmd_completed_irq), .cmd_timeout(cmd_timeout)
    );

    always @(negedge clk) begin
        if (cmd_completed_irq) irq_cnt++;
        if (encl_cmd_valid && encl_cmd_ready) begin
            fire_cnt++;
            last_fire = encl_cmd_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ctrl_write(input logic [31:0] d);
        ctrl_wr_en = 1'b1; ctrl_wr_data = d;
        step();
        ctrl_wr_en = 1'b0;
    endtask

    task automatic sts_write(input logic [31:0] d);
        sts_wr_en = 1'b1; sts_wr_data = d;
        step();
        sts_wr_en = 1'b0;
    endtask

    task automatic pulse_ready();
        encl_cmd_ready = 1'b1; step(); encl_cmd_ready = 1'b0;
    endtask

    task automatic pulse_done();
        encl_done = 1'b1; step(); encl_done = 1'b0;
    endtask

    typedef struct {
        logic [31:0] cap;
        logic [31:0] wr;
        logic [31:0] exp_rd;
        logic [31:0] exp_cmd;
        bit          exp_issue;
        bit          exp_irq;
    } vec_t;

    vec_t vecs[5];

    // randomized-run model: commands expected on the enclosure port, in order
    logic [31:0] exp_q[$];
    logic [31:0] ctrl_exp, latest, cap_r, wr_r, m;
    bit busy_m, have_latest, acked, in_complete, complete_now, irq_bit, pushed_now;
    bit wr_r_en, rdy_r, dn_r, draining;
    int irq_exp, compl_n, wait_v, wait_d, irq0, fire0;

    initial begin
        vecs[0] = '{32'h0000_003D, 32'h0000_0FFD, 32'h0000_003D, 32'h0000_003D, 1'b1, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFF00_0FFD, 32'hFF00_0FFF, 1'b1, 1'b1};
        vecs[2] = '{32'h0000_0003, 32'h0000_0002, 32'h0000_0000, 32'h0000_0002, 1'b1, 1'b0};
        vecs[3] = '{32'h1200_0801, 32'hFFFF_F0FF, 32'h1200_0001, 32'h1200_0001, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0FFE, 32'hFFFF_FFFF, 32'h1200_0001, 32'h0000_0000, 1'b0, 1'b0};

        rst_n = 1'b0; capabilities = '0; ctrl_wr_en = 1'b0; ctrl_wr_data = '0;
        sts_wr_en = 1'b0; sts_wr_data = '0; encl_cmd_ready = 1'b0; encl_done = 1'b0; encl_status = '0;
        step(2);
        rst_n = 1'b1;
        step();
        check("rst_ctrl_rd", ctrl_rd_data, 32'h0);
        check("rst_sts_rd", sts_rd_data, 32'h0);
        check("rst_valid", encl_cmd_valid, 32'h0);
        check("rst_cmd_data", encl_cmd_data, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_irq", cmd_completed_irq, 32'h0);
        check("rst_timeout", cmd_timeout, 32'h0);

        for (int i = 0; i < 5; i++) begin
            irq0 = irq_cnt;
            capabilities = vecs[i].cap;
            ctrl_write(vecs[i].wr);
            check("vec_ctrl_rd", ctrl_rd_data, vecs[i].exp_rd);
            check("vec_busy", busy, {31'b0, vecs[i].exp_issue});
            check("vec_valid", encl_cmd_valid, {31'b0, vecs[i].exp_issue});
            if (vecs[i].exp_issue) begin
                check("vec_cmd_data", encl_cmd_data, vecs[i].exp_cmd);
                step(3);
                check("vec_valid_hold", encl_cmd_valid, 32'h1);
                check("vec_cmd_stable", encl_cmd_data, vecs[i].exp_cmd);
                pulse_ready();
                check("vec_valid_drop", encl_cmd_valid, 32'h0);
                check("vec_busy_wait", busy, 32'h1);
                step(4);
                pulse_done();
                step();
                check("vec_sts_cc", sts_rd_data, 32'h1);
                check("vec_idle", busy, 32'h0);
                step();
                check("vec_irq_count", irq_cnt - irq0, {31'b0, vecs[i].exp_irq});
                sts_write(32'h1);
                check("vec_sts_clear", sts_rd_data, 32'h0);
            end
        end

        // writes B and C during WAIT_DONE collapse into one follow-up carrying C
        capabilities = 32'hFFFF_FFFF;
        irq0 = irq_cnt; fire0 = fire_cnt;
        ctrl_write(32'h1);
        pulse_ready();
        ctrl_write(32'h5);
        ctrl_write(32'h9);
        check("pend_ctrl_rd", ctrl_rd_data, 32'h9);
        check("pend_inflight_data", encl_cmd_data, 32'h1);
        check("pend_no_valid", encl_cmd_valid, 32'h0);
        pulse_done();
        step();
        check("pend_reissue_valid", encl_cmd_valid, 32'h1);
        check("pend_reissue_data", encl_cmd_data, 32'h9);
        pulse_ready();
        pulse_done();
        step(3);
        check("pend_fire_count", fire_cnt - fire0, 32'd2);
        check("pend_last_fire", last_fire, 32'h9);
        check("pend_irq_count", irq_cnt - irq0, 32'd2);
        check("pend_idle", busy, 32'h0);
        sts_write(32'h1);

        // stray done/ready while idle changes nothing
        fire0 = fire_cnt;
        pulse_done();
        pulse_ready();
        step();
        check("stray_busy", busy, 32'h0);
        check("stray_sts", sts_rd_data, 32'h0);
        check("stray_fire", fire_cnt - fire0, 32'd0);

        // completion set beats a same-cycle RW1C clear
        ctrl_write(32'h1);
        pulse_ready();
        pulse_done();
        sts_write(32'h1);
        check("rw1c_set_wins", sts_rd_data, 32'h1);
        sts_write(32'h1);
        check("rw1c_clear", sts_rd_data, 32'h0);

        // timeout: ISSUE entered at E0, ready at E1, forced COMPLETE at E16
        ctrl_write(32'h1);
        pulse_ready();
        step(14);
        check("tmo_busy_e15", busy, 32'h1);
        check("tmo_flag_e15", cmd_timeout, 32'h0);
        step();
        check("tmo_flag_e16", cmd_timeout, 32'h1);
        check("tmo_sts_e16", sts_rd_data, 32'h0);
        step();
        check("tmo_sts_e17", sts_rd_data, 32'h1);
        check("tmo_idle", busy, 32'h0);
        sts_write(32'h0);
        check("rw1c_write0_keeps", sts_rd_data, 32'h1);
        sts_write(32'h1);
        check("rw1c_clear2", sts_rd_data, 32'h0);
        check("tmo_sticky", cmd_timeout, 32'h1);

        // enclosure status mirror, one cycle of latency
        encl_status = 8'hA5;
        step();
        check("encl_sts_a5", sts_rd_data, 32'hA500_0000);
        encl_status = 8'h3C;
        #1;
        check("encl_sts_latency", sts_rd_data, 32'hA500_0000);
        step();
        check("encl_sts_3c", sts_rd_data, 32'h3C00_0000);
        encl_status = 8'h00;

        // reset while ISSUE is driving valid
        ctrl_write(32'h3);
        check("rstmid_valid", encl_cmd_valid, 32'h1);
        check("rstmid_data", encl_cmd_data, 32'h3);
        check("rstmid_ctrl_rd", ctrl_rd_data, 32'h1);
        irq0 = irq_cnt;
        rst_n = 1'b0;
        #1;
        check("rstmid_valid_drop", encl_cmd_valid, 32'h0);
        check("rstmid_busy_drop", busy, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("rstmid_ctrl", ctrl_rd_data, 32'h0);
        check("rstmid_sts", sts_rd_data, 32'h0);
        check("rstmid_idle", busy, 32'h0);
        check("rstmid_timeout", cmd_timeout, 32'h0);
        check("rstmid_no_irq", irq_cnt - irq0, 32'd0);

        // randomized traffic against a transaction-level model
        ctrl_exp = '0; busy_m = 0; have_latest = 0; acked = 0; in_complete = 0;
        irq_exp = 0; compl_n = 0; wait_v = 0; wait_d = 0; latest = '0;
        irq0 = irq_cnt;
        for (int cyc = 0; cyc < 2600; cyc++) begin
            draining = (cyc >= 2000);
            if (draining && exp_q.size() == 0 && !busy_m && !in_complete) break;
            check("rnd_ctrl_rd", ctrl_rd_data, ctrl_exp & 32'hFFFF_FFFD);

            cap_r = $urandom;
            if ($urandom_range(3) != 0) cap_r[0] = 1'b1;
            wr_r_en = !draining && ($urandom_range(4) == 0);
            wr_r    = $urandom;
            rdy_r   = ($urandom_range(1) == 1) || (wait_v >= 3);
            dn_r    = ($urandom_range(9) < 4) || (acked && wait_d >= 3);
            capabilities = cap_r; ctrl_wr_en = wr_r_en; ctrl_wr_data = wr_r;
            encl_cmd_ready = rdy_r; encl_done = dn_r;

            complete_now = in_complete; in_complete = 0;
            irq_bit = ctrl_exp[0];
            pushed_now = 0;
            if (wr_r_en && cap_r[0]) begin
                m = wr_r & cap_r & 32'hFF00_0FFF;
                ctrl_exp = m;
                if (!busy_m) begin
                    exp_q.push_back(m); busy_m = 1; pushed_now = 1;
                end else begin
                    latest = m; have_latest = 1;
                end
            end
            if (complete_now) begin
                compl_n++;
                if (irq_bit) irq_exp++;
                if (have_latest) begin
                    exp_q.push_back(latest); have_latest = 0; pushed_now = 1;
                end else begin
                    busy_m = 0;
                end
            end

            @(negedge clk);
            if (acked && dn_r) begin
                in_complete = 1; acked = 0; wait_d = 0;
            end else if (acked) begin
                wait_d++;
            end
            check("rnd_valid", encl_cmd_valid, {31'b0, (exp_q.size() > 0) && !pushed_now});
            if (encl_cmd_valid && exp_q.size() > 0) begin
                if (rdy_r) begin
                    check("rnd_cmd_data", encl_cmd_data, exp_q.pop_front());
                    acked = 1; wait_v = 0;
                end else begin
                    wait_v++;
                end
            end
            @(posedge clk);
            #1;
        end
        ctrl_wr_en = 1'b0; encl_cmd_ready = 1'b0; encl_done = 1'b0;
        step(3);
        check("rnd_drained", exp_q.size(), 32'd0);
        check("rnd_idle", busy, 32'h0);
        check("rnd_irq_count", irq_cnt - irq0, irq_exp);
        check("rnd_sts_cc", sts_rd_data, {31'b0, compl_n > 0});
        check("rnd_no_timeout", cmd_timeout, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
